fetch_prefetch_unit: RTL and testbench

Instruction-fetch front end for the pipelined CPU. It sits directly upstream of the IF/ID pipeline register and replaces the combinational imem lookup with a request/response fetch engine and a small in-order prefetch queue. It generates sequential fetch addresses, tolerates variable instruction-memory latency, and delivers {pc, instr} pairs to IF/ID under a stall signal. On a taken-branch redirect it flushes the queue and discards any responses still in flight.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_prefetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset vector, NOP encoding and
// the {pc, instr} record carried by the fetch queue.
package cpu_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] next_word_addr(input logic [ADDR_W-1:0] addr);
      return addr + ADDR_W'(4);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue of {pc, instr} entries; flush beats push/pop.
// Control state is reset; the storage array is not.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   input  logic               flush,
   output fetch_entry_t       head,
   output logic               full,
   output logic               empty,
   output logic [CNT_W-1:0]   count
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: credit-limited request engine, in-order
// response tracking with redirect drop counting, and a prefetch queue to IF/ID.
module fetch_prefetch_unit
   import cpu_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               stall,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  pc_out
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] fetch_pc_next;
   logic [ADDR_W-1:0] rsp_pc;
   logic [ADDR_W-1:0] rsp_pc_next;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  inflight;
   logic [CNT_W-1:0]  inflight_next;
   logic [CNT_W-1:0]  drop_cnt;
   logic [CNT_W-1:0]  drop_cnt_next;
   logic [CNT_W:0]    credit_used;

   logic              req_fire;
   logic              rsp_drop;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   fetch_entry_t      fifo_head;
   fetch_entry_t      fifo_push_data;

   // Queued entries plus outstanding requests never exceed the queue size,
   // so a response always has a slot and needs no backpressure.
   assign credit_used    = {1'b0, count} + {1'b0, inflight};
   assign imem_req_valid = reset && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_drop       = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
   assign fifo_push      = imem_rsp_valid && !rsp_drop;
   assign fifo_pop       = !fifo_empty && !stall && !redirect_valid;
   assign fifo_push_data = '{pc: rsp_pc, instr: imem_rsp_data};

   assign instr_valid    = !fifo_empty;
   assign instr_out      = fifo_empty ? NOP_INSTR : fifo_head.instr;
   assign pc_out         = fifo_empty ? '0 : fifo_head.pc;

   always_comb begin
      inflight_next = inflight;
      if (req_fire && !imem_rsp_valid) begin
         inflight_next = inflight + CNT_W'(1);
      end else if (!req_fire && imem_rsp_valid) begin
         inflight_next = inflight - CNT_W'(1);
      end
   end

   // On redirect everything still outstanding becomes stale; a response in
   // the redirect cycle itself is already excluded from inflight_next.
   always_comb begin
      drop_cnt_next = drop_cnt;
      fetch_pc_next = fetch_pc;
      rsp_pc_next   = rsp_pc;
      if (redirect_valid) begin
         drop_cnt_next = inflight_next;
         fetch_pc_next = redirect_pc;
         rsp_pc_next   = redirect_pc;
      end else begin
         if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt_next = drop_cnt - CNT_W'(1);
         if (req_fire)  fetch_pc_next = next_word_addr(fetch_pc);
         if (fifo_push) rsp_pc_next   = next_word_addr(rsp_pc);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         fetch_pc <= fetch_pc_next;
         rsp_pc   <= rsp_pc_next;
         inflight <= inflight_next;
         drop_cnt <= drop_cnt_next;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (fifo_pop),
      .flush     (redirect_valid),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

`ifndef SYNTHESIS
   a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (!reset)
      imem_rsp_valid |-> (inflight != '0))
      else $error("response arrived with no request outstanding");

   a_redirect_aligned: assert property (@(posedge clk) disable iff (!reset)
      redirect_valid |-> (redirect_pc[1:0] == 2'b00))
      else $error("redirect target not word aligned");

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      fifo_push |-> (!fifo_full || fifo_pop))
      else $error("prefetch queue overflow");
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: queue-level reference model, latency-configurable
// memory, directed scenarios plus a randomised ready/stall phase.
module tb_fetch_prefetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;

   always #5 clk = ~clk;

   fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .instr_valid    (instr_valid),
      .instr_out      (instr_out),
      .pc_out         (pc_out)
   );

   typedef struct { logic [31:0] addr; int due; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

   pend_t pend[$];
   ent_t  mq[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   logic [31:0] m_fetch, m_rsp;
   int          m_infl, m_drop;

   logic        t_reset, t_ready, t_stall, t_redir;
   logic [31:0] t_rpc;

   logic        o_fire, o_pop, o_req_valid;
   logic [31:0] o_fire_addr, o_pop_pc, o_pop_instr;
   logic        sb_have;
   logic [31:0] sb_prev;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hC0DE_1357;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, let outputs settle, compare, advance model.
   task automatic step();
      logic exp_rv;
      @(negedge clk);
      reset          = t_reset;
      imem_req_ready = t_ready;
      stall          = t_stall;
      redirect_valid = t_redir;
      redirect_pc    = t_rpc;
      if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memf(pend[0].addr);
         pend.delete(0);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hBAD0_BAD0;
      end
      #1;
      o_req_valid = imem_req_valid;
      o_fire      = reset && imem_req_valid && imem_req_ready;
      o_fire_addr = imem_req_addr;
      o_pop       = instr_valid && !stall && !redirect_valid;
      o_pop_pc    = pc_out;
      o_pop_instr = instr_out;
      if (!reset) begin
         chk("rst_instr_valid", instr_valid, 0);
         chk("rst_req_valid", imem_req_valid, 0);
         chk("rst_req_addr", imem_req_addr, 32'h0);
         chk("rst_instr_out", instr_out, 32'h0);
         chk("rst_pc_out", pc_out, 32'h0);
         mq.delete();
         pend.delete();
         m_fetch = 32'h0; m_rsp = 32'h0; m_infl = 0; m_drop = 0;
         sb_have = 1'b0;
      end else begin
         exp_rv = !t_redir && ((mq.size() + m_infl) < DEPTH);
         chk("req_valid", imem_req_valid, exp_rv);
         chk("req_addr", imem_req_addr, m_fetch);
         chk("instr_valid", instr_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("pc_out", pc_out, mq[0].pc);
            chk("instr_out", instr_out, mq[0].instr);
         end
         if (o_pop) begin
            chk("mem_word", instr_out, memf(pc_out));
            if (sb_have) chk("pc_step", pc_out, sb_prev + 32'd4);
            sb_have = 1'b1;
            sb_prev = pc_out;
         end
         if (o_fire) pend.push_back('{imem_req_addr, cyc + lat});
         if (t_redir) begin
            mq.delete();
            m_fetch = t_rpc;
            m_rsp   = t_rpc;
            if (imem_rsp_valid) m_infl--;
            m_drop  = m_infl;
            sb_have = 1'b0;
         end else begin
            if (mq.size() != 0 && !t_stall) mq.delete(0);
            if (imem_rsp_valid) begin
               m_infl--;
               if (m_drop > 0) m_drop--;
               else begin
                  mq.push_back('{m_rsp, imem_rsp_data});
                  m_rsp += 32'd4;
               end
            end
            if (exp_rv && t_ready) begin
               m_fetch += 32'd4;
               m_infl++;
            end
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      t_reset = 1'b0;
      repeat (2) step();
      t_reset = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          rel, first_valid, nfire, npop, n;
      logic        ok;
      logic        red_rv;
      logic [31:0] fa[3];
      logic [31:0] pa[4];

      reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
      t_reset = 1'b0; t_ready = 1'b1; t_stall = 1'b0; t_redir = 1'b0; t_rpc = '0;
      sb_have = 1'b0; sb_prev = '0;
      repeat (3) step();

      // Reset release, single-cycle memory, free-running
      t_reset = 1'b1; rel = cyc; first_valid = -1; nfire = 0; npop = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (instr_valid && first_valid < 0) first_valid = cyc - 1 - rel;
         if (o_fire && nfire < 3) begin fa[nfire] = o_fire_addr; nfire++; end
         if (o_pop && npop < 3) begin pa[npop] = o_pop_pc; npop++; end
      end
      chk("first_valid_latency", first_valid, 2);
      chk("req_addr0", fa[0], 32'h0);
      chk("req_addr1", fa[1], 32'h4);
      chk("req_addr2", fa[2], 32'h8);
      chk("pop_pc0", pa[0], 32'h0);
      chk("pop_pc1", pa[1], 32'h4);
      chk("pop_pc2", pa[2], 32'h8);

      // Stall held: credits exhaust at DEPTH, then drain in order
      t_reset = 1'b0; repeat (2) step();
      t_reset = 1'b1; t_stall = 1'b1; nfire = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (o_fire) nfire++;
      end
      chk("stall_fire_count", nfire, 4);
      chk("stall_head_pc", pc_out, 32'h0);
      t_stall = 1'b0; npop = 0;
      for (int i = 0; i < 20 && npop < 4; i++) begin
         step();
         if (o_pop) begin pa[npop] = o_pop_pc; npop++; end
      end
      chk("drain_pops", npop, 4);
      chk("drain_pc0", pa[0], 32'h0);
      chk("drain_pc1", pa[1], 32'h4);
      chk("drain_pc2", pa[2], 32'h8);
      chk("drain_pc3", pa[3], 32'hC);

      // Three-cycle memory with three requests outstanding, then redirect
      do_reset();
      lat = 3; ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         step();
         ok = (m_infl == 3);
      end
      chk("lat3_setup", ok, 1);
      t_redir = 1'b1; t_rpc = 32'h100;
      step();
      t_redir = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         ok = o_pop;
      end
      chk("redir_pop_seen", ok, 1);
      chk("redir_pop_pc", o_pop_pc, 32'h100);
      chk("redir_pop_instr", o_pop_instr, 32'hC0DE_1257);

      // Redirect coinciding with a response arrival and a pop
      do_reset();
      lat = 1; ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         ok = (mq.size() > 0) && (pend.size() > 0) && (pend[0].due == cyc);
      end
      chk("same_cycle_setup", ok, 1);
      t_redir = 1'b1; t_rpc = 32'h40;
      step();
      red_rv = o_req_valid;
      t_redir = 1'b0;
      step();
      chk("redir_no_req", red_rv, 0);
      chk("redir_empty_next", instr_valid, 0);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         ok = o_pop;
      end
      chk("redir2_pop_pc", o_pop_pc, 32'h40);
      chk("redir2_pop_instr", o_pop_instr, 32'hC0DE_1317);

      // Randomised ready/stall with occasional redirects
      lat = 2;
      for (int i = 0; i < 1000; i++) begin
         t_ready = 1'($urandom_range(0, 1));
         t_stall = ($urandom_range(0, 3) == 0);
         t_redir = ((i % 97) == 50);
         n       = int'($urandom_range(0, 63));
         t_rpc   = 32'h1000 + 32'(n * 4);
         step();
      end
      t_redir = 1'b0; t_ready = 1'b1;

      // Asynchronous reset with a full queue, then restart at the reset vector
      lat = 1; t_stall = 1'b1;
      repeat (10) step();
      chk("full_before_reset", instr_valid, 1);
      @(negedge clk);
      #3;
      reset = 1'b0; t_reset = 1'b0;
      #1;
      chk("async_instr_valid", instr_valid, 0);
      chk("async_req_valid", imem_req_valid, 0);
      repeat (2) step();
      t_reset = 1'b1; t_stall = 1'b0;
      step();
      chk("restart_fire", o_fire, 1);
      chk("restart_addr", o_fire_addr, 32'h0);
      repeat (6) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
